udma_hyper_txconv: RTL

Parametrised TX width/alignment converter between the uDMA TX stream (SRC_W bits per word) and the HyperBus PHY (DST_W bits per beat).
- Runs one transfer of LEN PHY beats per start pulse.
- Realigns the byte stream for an unaligned start byte offset and optionally byte-swaps each beat.
- In register-space mode it substitutes a constant register value for the memory data.
- Sits between the uDMA TX FIFO and the PHY TX port inside the hyper channel.

---
 rtl/udma_hyper_txconv.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/udma_hyper_txconv.sv
// uDMA TX word stream to HyperBus PHY beat converter with start-offset realignment and byte swap.
// Optional stall counter enabled by defining UDMA_TXCONV_STALL_CNT_EN.
module udma_hyper_txconv #(
  parameter int  SRC_W      = 32,
  parameter int  DST_W      = 16,
  parameter int  TRANS_SIZE = 16,
  localparam int SRC_B      = SRC_W / 8,
  localparam int OFFS_W     = (SRC_B > 1) ? $clog2(SRC_B) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [TRANS_SIZE-1:0] cfg_len_i,
  input  logic [OFFS_W-1:0]     cfg_offset_i,
  input  logic                  cfg_swap_i,
  input  logic                  cfg_addr_space_i,
  input  logic [15:0]           cfg_reg_data_i,
  input  logic                  src_valid_i,
  output logic                  src_ready_o,
  input  logic [SRC_W-1:0]      src_data_i,
  output logic                  dst_valid_o,
  input  logic                  dst_ready_i,
  output logic [DST_W-1:0]      dst_data_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [15:0]           stall_cnt_o
);

  localparam int DST_B  = DST_W / 8;
  localparam int BUF_B  = 2 * SRC_B;
  localparam int BUF_W  = BUF_B * 8;
  localparam int BCNT_W = $clog2(BUF_B + 1);
  localparam int REM_W  = TRANS_SIZE + 3;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [BCNT_W-1:0] SRC_B_C = BCNT_W'(SRC_B);
  localparam logic [BCNT_W-1:0] DST_B_C = BCNT_W'(DST_B);

  logic [1:0]            state_r, state_s;
  logic [TRANS_SIZE-1:0] len_r, ld_cnt_r;
  logic [OFFS_W-1:0]     offs_r;
  logic                  swap_r, as_r, first_r;
  logic [15:0]           reg_r;
  logic [BUF_W-1:0]      buf_r, push_data_s, ext_buf_s, buf_nxt_s;
  logic [BCNT_W-1:0]     bcnt_r, push_cnt_s, ext_cnt_s, bcnt_nxt_s;
  logic [REM_W-1:0]      rem_s;
  logic [DST_W-1:0]      beat_s, dst_data_r;
  logic                  dst_valid_r, push_s, load_s, last_hs_s;

  // Bytes still owed to the PHY; stops the source being read past the transfer end.
  assign rem_s       = REM_W'(len_r - ld_cnt_r) << $clog2(DST_B);
  assign src_ready_o = (state_r == RUN) && !as_r && (bcnt_r <= SRC_B_C) && (rem_s > REM_W'(bcnt_r));
  assign push_s      = src_ready_o && src_valid_i;
  assign last_hs_s   = (state_r == RUN) && dst_valid_r && dst_ready_i && (ld_cnt_r == len_r);

  // Merge the incoming word above buffered bytes and form the next beat from the merged view.
  always_comb begin
    push_data_s = '0;
    push_cnt_s  = '0;
    beat_s      = '0;
    if (push_s) begin
      if (first_r) begin
        push_data_s = BUF_W'(src_data_i >> {offs_r, 3'b000});
        push_cnt_s  = SRC_B_C - BCNT_W'(offs_r);
      end else begin
        push_data_s = BUF_W'(src_data_i);
        push_cnt_s  = SRC_B_C;
      end
    end else begin
      push_data_s = '0;
      push_cnt_s  = '0;
    end
    ext_buf_s = buf_r | (push_data_s << {bcnt_r, 3'b000});
    ext_cnt_s = bcnt_r + push_cnt_s;
    load_s    = (state_r == RUN) && (!dst_valid_r || dst_ready_i) && (ld_cnt_r < len_r) &&
                (as_r || (ext_cnt_s >= DST_B_C));
    if (as_r) begin
      beat_s = DST_W'(reg_r);
    end else if (swap_r) begin
      for (int b = 0; b < DST_B; b++) begin
        beat_s[8*b +: 8] = ext_buf_s[8*(DST_B-1-b) +: 8];
      end
    end else begin
      beat_s = ext_buf_s[DST_W-1:0];
    end
    if (load_s && !as_r) begin
      buf_nxt_s  = ext_buf_s >> DST_W;
      bcnt_nxt_s = ext_cnt_s - DST_B_C;
    end else begin
      buf_nxt_s  = ext_buf_s;
      bcnt_nxt_s = ext_cnt_s;
    end
  end

  // Next-state selection; abort overrides every transition.
  always_comb begin
    state_s = state_r;
    if (abort_i) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = start_i ? ((cfg_len_i == '0) ? DONE : RUN) : IDLE;
        RUN:     state_s = last_hs_s ? DRAIN : RUN;
        DRAIN:   state_s = DONE;
        DONE:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State, configuration latch, byte buffer and output beat register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      len_r       <= '0;
      ld_cnt_r    <= '0;
      offs_r      <= '0;
      swap_r      <= 1'b0;
      as_r        <= 1'b0;
      first_r     <= 1'b0;
      reg_r       <= 16'h0000;
      buf_r       <= '0;
      bcnt_r      <= '0;
      dst_valid_r <= 1'b0;
      dst_data_r  <= '0;
    end else if (abort_i) begin
      state_r     <= IDLE;
      ld_cnt_r    <= '0;
      first_r     <= 1'b0;
      buf_r       <= '0;
      bcnt_r      <= '0;
      dst_valid_r <= 1'b0;
    end else begin
      state_r <= state_s;
      case (state_r)
        IDLE: begin
          if (start_i) begin
            len_r    <= cfg_len_i;
            offs_r   <= cfg_offset_i;
            swap_r   <= cfg_swap_i;
            as_r     <= cfg_addr_space_i;
            reg_r    <= cfg_reg_data_i;
            first_r  <= 1'b1;
            ld_cnt_r <= '0;
            buf_r    <= '0;
            bcnt_r   <= '0;
          end
        end
        RUN: begin
          buf_r  <= buf_nxt_s;
          bcnt_r <= bcnt_nxt_s;
          if (push_s) first_r <= 1'b0;
          if (load_s) begin
            dst_data_r  <= beat_s;
            dst_valid_r <= 1'b1;
            ld_cnt_r    <= ld_cnt_r + TRANS_SIZE'(1);
          end else if (dst_ready_i) begin
            dst_valid_r <= 1'b0;
          end
        end
        DRAIN: begin
          buf_r       <= '0;
          bcnt_r      <= '0;
          dst_valid_r <= 1'b0;
        end
        default: begin
          dst_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign dst_valid_o = dst_valid_r;
  assign dst_data_o  = dst_data_r;
  assign busy_o      = (state_r == RUN) || (state_r == DRAIN);
  assign done_o      = (state_r == DONE);

`ifdef UDMA_TXCONV_STALL_CNT_EN
  logic [15:0] stall_r;

  // Saturating count of cycles the PHY holds off a valid beat.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_r <= 16'h0000;
    end else if (abort_i || ((state_r == IDLE) && start_i)) begin
      stall_r <= 16'h0000;
    end else if ((state_r != IDLE) && dst_valid_r && !dst_ready_i && (stall_r != 16'hFFFF)) begin
      stall_r <= stall_r + 16'd1;
    end else begin
      stall_r <= stall_r;
    end
  end

  assign stall_cnt_o = stall_r;
`else
  assign stall_cnt_o = 16'h0000;
`endif

endmodule
